// File: rtl/decode_pkg.sv
// Shared decode constants: instruction field positions, buffer depth and PC offset.
// Also used by the control unit and the immediate-extension stage.
package decode_pkg;

   localparam int COND_HI   = 31;
   localparam int COND_LO   = 28;
   localparam int OP_HI     = 27;
   localparam int OP_LO     = 26;
   localparam int FUNCT_HI  = 25;
   localparam int FUNCT_LO  = 20;
   localparam int RN_HI     = 19;
   localparam int RN_LO     = 16;
   localparam int RD_HI     = 15;
   localparam int RD_LO     = 12;
   localparam int IMM_HI    = 11;
   localparam int IMM_LO    = 0;

   localparam int DEPTH     = 2;
   localparam int PC_OFFSET = 8;

   typedef struct packed {
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [11:0] imm12;
   } fields_t;

   function automatic fields_t slice_fields(input logic [31:0] instr);
      fields_t f;
      f.cond  = instr[COND_HI:COND_LO];
      f.op    = instr[OP_HI:OP_LO];
      f.funct = instr[FUNCT_HI:FUNCT_LO];
      f.rn    = instr[RN_HI:RN_LO];
      f.rd    = instr[RD_HI:RD_LO];
      f.imm12 = instr[IMM_HI:IMM_LO];
      return f;
   endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Small FIFO skid buffer: DEPTH entries of WIDTH bits with pointer and occupancy tracking.
// Flush empties the buffer and takes priority over any push or pop in the same cycle.
module instr_skid_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == '0);
   assign do_push_s = push && !full && !flush;
   assign do_pop_s  = pop && !empty && !flush;
   assign rd_data   = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Entry storage; contents are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/instr_decode_reg.sv
// Decode pipeline register: buffers fetched instructions and presents the head entry's
// decoded fields and PC+8 to execute. Outputs come only from stored state.
module instr_decode_reg #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = decode_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [DATA_W-1:0] in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_cond,
   output logic [1:0]        out_op,
   output logic [5:0]        out_funct,
   output logic [3:0]        out_rn,
   output logic [3:0]        out_rd,
   output logic [11:0]       out_imm12,
   output logic [DATA_W-1:0] out_pc_plus8,
   output logic [1:0]        out_count
);

   import decode_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [2*DATA_W-1:0] head_s;
   logic [DATA_W-1:0]   head_instr_s;
   logic [DATA_W-1:0]   head_pc_s;
   logic [CNT_W-1:0]    count_s;
   logic                full_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic                rdy_en_r;
   fields_t             fields_s;
   logic [DATA_W-1:0]   pc8_s;

   // Holds in_ready low during reset and releases it on the first edge afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_en_r <= 1'b0;
      end else begin
         rdy_en_r <= 1'b1;
      end
   end

   assign in_ready  = rdy_en_r && !full_s && !flush;
   assign out_valid = !empty_s;
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   instr_skid_buf #(
      .WIDTH (2 * DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data ({in_pc, in_instr}),
      .rd_data (head_s),
      .count   (count_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   assign head_instr_s = head_s[DATA_W-1:0];
   assign head_pc_s    = head_s[2*DATA_W-1:DATA_W];

   // Field slicing and PC adder; everything is forced to zero while the buffer is empty.
   always_comb begin
      fields_s = '0;
      pc8_s    = '0;
      if (!empty_s) begin
         fields_s = slice_fields(head_instr_s[31:0]);
         pc8_s    = head_pc_s + DATA_W'(PC_OFFSET);
      end else begin
         fields_s = '0;
         pc8_s    = '0;
      end
   end

   assign out_cond     = fields_s.cond;
   assign out_op       = fields_s.op;
   assign out_funct    = fields_s.funct;
   assign out_rn       = fields_s.rn;
   assign out_rd       = fields_s.rd;
   assign out_imm12    = fields_s.imm12;
   assign out_pc_plus8 = pc8_s;
   assign out_count    = 2'(count_s);

endmodule

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_decode_reg;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = 32'h0;
   logic [31:0] in_pc = 32'h0;
   logic        in_ready;
   logic        out_valid;
   logic [3:0]  out_cond;
   logic [1:0]  out_op;
   logic [5:0]  out_funct;
   logic [3:0]  out_rn;
   logic [3:0]  out_rd;
   logic [11:0] out_imm12;
   logic [31:0] out_pc_plus8;
   logic [1:0]  out_count;

   instr_decode_reg #(.DATA_W(32), .DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_cond(out_cond), .out_op(out_op), .out_funct(out_funct),
      .out_rn(out_rn), .out_rd(out_rd), .out_imm12(out_imm12),
      .out_pc_plus8(out_pc_plus8), .out_count(out_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [11:0] imm;
      logic [31:0] pc8;
   } vec_t;

   vec_t vecs[5];
   logic [31:0] mq_instr[$];
   logic [31:0] mq_pc[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected head view derived from the instruction word by shifting and masking.
   task automatic check_head(input string tag, input int cnt, input logic [31:0] ei, input logic [31:0] ep);
      logic [31:0] c, o, f, n, d, m, p;
      if (cnt == 0) begin
         c = 0; o = 0; f = 0; n = 0; d = 0; m = 0; p = 0;
      end else begin
         c = ei >> 28;
         o = (ei >> 26) & 32'd3;
         f = (ei >> 20) & 32'd63;
         n = (ei >> 16) & 32'd15;
         d = (ei >> 12) & 32'd15;
         m = ei & 32'hFFF;
         p = ep + 32'd8;
      end
      check({tag, ".count"}, 64'(out_count), 64'(cnt));
      check({tag, ".valid"}, 64'(out_valid), 64'(cnt != 0));
      check({tag, ".cond"},  64'(out_cond),  64'(c));
      check({tag, ".op"},    64'(out_op),    64'(o));
      check({tag, ".funct"}, 64'(out_funct), 64'(f));
      check({tag, ".rn"},    64'(out_rn),    64'(n));
      check({tag, ".rd"},    64'(out_rd),    64'(d));
      check({tag, ".imm"},   64'(out_imm12), 64'(m));
      check({tag, ".pc8"},   64'(out_pc_plus8), 64'(p));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{32'hE3A0_1005, 32'h0000_0100, 4'hE, 2'b00, 6'h3A, 4'h0, 4'h1, 12'h005, 32'h0000_0108};
      vecs[1] = '{32'h1234_5678, 32'hFFFF_FFFC, 4'h1, 2'b00, 6'h23, 4'h4, 4'h5, 12'h678, 32'h0000_0004};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFF8, 4'hF, 2'b11, 6'h3F, 4'hF, 4'hF, 12'hFFF, 32'h0000_0000};
      vecs[3] = '{32'h0C00_0000, 32'h0000_0000, 4'h0, 2'b11, 6'h00, 4'h0, 4'h0, 12'h000, 32'h0000_0008};
      vecs[4] = '{32'h5A5A_5A5A, 32'h7FFF_FFFC, 4'h5, 2'b10, 6'h25, 4'hA, 4'h5, 12'hA5A, 32'h8000_0004};

      // Reset state
      #12;
      check("rst.in_ready", 64'(in_ready), 64'd0);
      check_head("rst", 0, 32'h0, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("rel.in_ready", 64'(in_ready), 64'd1);
      check("rel.valid", 64'(out_valid), 64'd0);

      // Directed vector table
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
         tick();
         in_valid = 1'b0;
         check($sformatf("vec%0d.valid", i), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d.cond", i),  64'(out_cond),  64'(vecs[i].cond));
         check($sformatf("vec%0d.op", i),    64'(out_op),    64'(vecs[i].op));
         check($sformatf("vec%0d.funct", i), 64'(out_funct), 64'(vecs[i].funct));
         check($sformatf("vec%0d.rn", i),    64'(out_rn),    64'(vecs[i].rn));
         check($sformatf("vec%0d.rd", i),    64'(out_rd),    64'(vecs[i].rd));
         check($sformatf("vec%0d.imm", i),   64'(out_imm12), 64'(vecs[i].imm));
         check($sformatf("vec%0d.pc8", i),   64'(out_pc_plus8), 64'(vecs[i].pc8));
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check($sformatf("vec%0d.drained", i), 64'(out_count), 64'd0);
         check($sformatf("vec%0d.zero_pc8", i), 64'(out_pc_plus8), 64'd0);
      end

      // Back-to-back pushes with a stalled consumer
      in_valid = 1'b1; in_instr = 32'hA000_0001; in_pc = 32'h200;
      #1 check("b2b.rdy0", 64'(in_ready), 64'd1);
      tick();
      in_instr = 32'hB000_0002; in_pc = 32'h204;
      #1 check("b2b.rdy1", 64'(in_ready), 64'd1);
      tick();
      in_instr = 32'hC000_0003; in_pc = 32'h208;
      #1 check("b2b.rdy2", 64'(in_ready), 64'd0);
      check_head("b2b.full", 2, 32'hA000_0001, 32'h200);
      tick();
      check_head("b2b.held", 2, 32'hA000_0001, 32'h200);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check_head("b2b.pop1", 1, 32'hB000_0002, 32'h204);
      tick();
      check_head("b2b.pop2", 0, 32'h0, 32'h0);
      out_ready = 1'b0;

      // Push and pop together at count 1
      in_valid = 1'b1; in_instr = 32'h1111_1111; in_pc = 32'h300;
      tick();
      in_instr = 32'h2222_2222; in_pc = 32'h304; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_head("pp", 1, 32'h2222_2222, 32'h304);
      tick();
      out_ready = 1'b0;
      check("pp.empty", 64'(out_count), 64'd0);

      // Flush while full with a push pending
      in_valid = 1'b1; in_instr = 32'h3333_3333; in_pc = 32'h400;
      tick();
      in_instr = 32'h4444_4444; in_pc = 32'h404;
      tick();
      in_instr = 32'h5555_5555; in_pc = 32'h408; flush = 1'b1; out_ready = 1'b1;
      #1 check("fl.in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_head("fl", 0, 32'h0, 32'h0);
      tick();
      check("fl.discard", 64'(out_count), 64'd0);

      // Asynchronous reset mid-cycle with a full buffer
      in_valid = 1'b1; in_instr = 32'h6666_6666; in_pc = 32'h500;
      tick();
      in_instr = 32'h7777_7777; in_pc = 32'h504;
      tick();
      in_valid = 1'b0;
      check("ar.full", 64'(out_count), 64'd2);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_head("ar", 0, 32'h0, 32'h0);
      check("ar.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("ar.rel_ready", 64'(in_ready), 64'd1);
      check("ar.rel_valid", 64'(out_valid), 64'd0);

      // Randomized traffic against the queue model
      for (int c = 0; c < 400; c++) begin
         logic acc, pop;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = $urandom;
         in_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         check("rnd.in_ready", 64'(in_ready), 64'((mq_instr.size() < 2) && !flush));
         acc = in_valid && (mq_instr.size() < 2) && !flush;
         pop = out_ready && (mq_instr.size() > 0) && !flush;
         @(posedge clk);
         if (flush) begin
            mq_instr.delete();
            mq_pc.delete();
         end else begin
            if (pop) begin
               void'(mq_instr.pop_front());
               void'(mq_pc.pop_front());
            end
            if (acc) begin
               mq_instr.push_back(in_instr);
               mq_pc.push_back(in_pc);
            end
         end
         #1;
         if (mq_instr.size() > 0) begin
            check_head("rnd", mq_instr.size(), mq_instr[0], mq_pc[0]);
         end else begin
            check_head("rnd", 0, 32'h0, 32'h0);
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_decode_reg.md
INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction and PC width.
REQ-002 SHALL have parameter DEPTH, default 2: entries in the internal skid buffer. Only 2 is required to be supported.
REQ-003 SHALL have port clk, in, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, in, 1: the fetch stage presents an instruction.
REQ-006 SHALL have port in_ready, out, 1: the block can accept an instruction this cycle.
REQ-007 SHALL have port in_instr, in, DATA_W: fetched instruction word.
REQ-008 SHALL have port in_pc, in, DATA_W: address of in_instr.
REQ-009 SHALL have port flush, in, 1: discard all buffered instructions (branch taken).
REQ-010 SHALL have port out_valid, out, 1: a decoded instruction is presented at the head.
REQ-011 SHALL have port out_ready, in, 1: the downstream execute stage consumes the head entry.
REQ-012 SHALL have port out_cond, out, 4: instr[31:28].
REQ-013 SHALL have port out_op, out, 2: instr[27:26].
REQ-014 SHALL have port out_funct, out, 6: instr[25:20].
REQ-015 SHALL have port out_rn, out, 4: instr[19:16].
REQ-016 SHALL have port out_rd, out, 4: instr[15:12].
REQ-017 SHALL have port out_imm12, out, 12: instr[11:0]; this drives the Immediate input of the immediate-extension stage.
REQ-018 SHALL have port out_pc_plus8, out, DATA_W: the head entry's PC + 8, modulo 2^DATA_W.
REQ-019 SHALL have port out_count, out, 2: current buffer occupancy, 0..2.

Function
REQ-020 SHALL accept an instruction when in_valid && in_ready, and SHALL pop the head when out_valid && out_ready.
REQ-021 SHALL drive in_ready = (count < DEPTH) && !flush.
REQ-022 SHALL drive out_valid = (count != 0).
REQ-023 SHALL store each accepted in_instr/in_pc as one entry and preserve entries in FIFO order.
REQ-024 SHALL give a latency of 1 cycle: an entry accepted into an empty buffer appears on out_* after the next edge.
REQ-025 SHALL derive all out_* field ports from the head entry's stored registers only, with no combinational path from in_* to out_*.
REQ-026 SHALL compute out_pc_plus8 from the stored PC with wrap-around; PC 32'hFFFF_FFFC yields 32'h0000_0004.
REQ-027 SHALL, on simultaneous push and pop at count 1, present the new entry at the head and keep count at 1.
REQ-028 SHALL, on simultaneous push and pop at count 0, not occur, because out_valid is low.
REQ-029 SHALL block push when count is 2 (in_ready low); a pop in that cycle reduces count to 1.
REQ-030 SHALL hold the head entry and all out_* ports stable while out_valid && !out_ready.
REQ-031 SHALL, on flush high at an edge, set count to 0; any concurrent push and pop are ignored, and out_valid is low the following cycle.
REQ-032 SHALL leave out_* field values don't-care while out_valid is low, but SHALL drive them to 0 whenever count is 0.

Reset
REQ-033 SHALL, while reset_n is low, immediately and asynchronously force count to 0, out_valid to 0, all out_* fields to 0, and both read/write pointers to 0.
REQ-034 SHALL hold in_ready at 0 while reset_n is low, and SHALL raise in_ready to 1 the first cycle after reset_n deasserts.
REQ-035 SHALL, on reset asserted mid-transfer, lose buffered entries without a partial pop; no out_valid pulse follows reset release.

Structure
REQ-036 SHALL place the field bit-position constants (COND_HI/LO, OP_HI/LO, FUNCT_HI/LO, RN_HI/LO, RD_HI/LO, IMM_HI/LO), DEPTH and PC_OFFSET = 8 in a shared package, decode_pkg, also used by the control unit and the immediate-extension stage.
REQ-037 SHALL implement storage and pointer/count logic as one sub-module, instr_skid_buf (DATA_W*2 wide, DEPTH entries), with field slicing and PC adder in the top.

Verification
REQ-038 Bench SHALL cover: reset release, then push instr 32'hE3A0_1005, pc 32'h100 -> next cycle out_valid=1, out_cond=4'hE, out_op=2'b00, out_funct=6'h3A, out_rd=4'h1, out_imm12=12'h005, out_pc_plus8=32'h108.
REQ-039 Bench SHALL cover: out_ready=0, push 3 instrs back-to-back -> in_ready falls after 2 accepts, out_count=2, the third is held by fetch, and the head is unchanged.
REQ-040 Bench SHALL cover: count=1, push and pop in the same cycle -> out_count stays 1 and the head becomes the newly pushed instruction.
REQ-041 Bench SHALL cover: count=2 with flush and in_valid high -> next cycle out_count=0, out_valid=0, and the pushed instruction is discarded.
REQ-042 Bench SHALL cover: pc 32'hFFFF_FFFC -> out_pc_plus8=32'h0000_0004.
REQ-043 Bench SHALL cover: reset_n driven low asynchronously mid-cycle with count=2 -> out_valid=0 and out_count=0 before the next edge, with all fields 0.
